// File: rtl/simplebus_burst_follower.sv
// Simple-bus memory follower with multiplexed address beats, bursts,
// configurable read latency, range checking and write timeout.
module simplebus_burst_follower #(
    parameter int BUS_W   = 8,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 65536,
    parameter int RD_LAT  = 2,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_read,
    input  logic [LEN_W-1:0] i_len,
    input  logic [BUS_W-1:0] i_address,
    input  logic [BUS_W-1:0] i_data_in,
    input  logic             i_dv_in,
    output logic [BUS_W-1:0] o_data_out,
    output logic             o_data_oe,
    output logic             o_dv_out,
    output logic             o_busy,
    output logic             o_err
);

    localparam int AB   = (ADDR_W + BUS_W - 1) / BUS_W;
    localparam int AB_W = $clog2(AB + 1);
    localparam int TM_W = $clog2(TIMEOUT + 1);
    localparam int RL_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int TW   = (TM_W > RL_W) ? TM_W : RL_W;
    localparam int MA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RWAIT,
        RDATA,
        WDATA
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_shift;
    logic [AB_W-1:0]    r_abeat;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [TW-1:0]      r_timer;
    logic               r_oor;
    logic               r_err;
    logic               r_dv;
    logic               r_busy;
    logic [BUS_W-1:0]   r_data;
    logic [BUS_W-1:0]   r_mem [DEPTH];

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_shift_nxt;
    logic [AB_W-1:0]    w_abeat_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [TW-1:0]      w_timer_nxt;
    logic               w_oor_nxt;
    logic               w_err_nxt;
    logic               w_dv_nxt;
    logic [BUS_W-1:0]   w_data_nxt;
    logic               w_we;
    logic               w_final;

    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_full;
    logic               w_full_oor;
    logic [ADDR_W-1:0]  w_src;
    logic               w_src_oor;
    logic [ADDR_W-1:0]  w_src_inc;
    logic [BUS_W-1:0]   w_rd_word;
    logic [MA_W-1:0]    w_ridx;
    logic [MA_W-1:0]    w_widx;

    // Each new beat shifts in below the previous; excess MS bits fall off.
    assign w_base     = (r_state == IDLE) ? '0 : r_shift;
    assign w_full     = ADDR_W'({w_base, i_address});
    assign w_full_oor = 64'(w_full) >= 64'(DEPTH);

    // First read beat with RD_LAT=0 comes straight from the incoming address.
    assign w_src     = (r_state == RDATA || r_state == RWAIT) ? r_addr : w_full;
    assign w_src_oor = (r_state == RDATA || r_state == RWAIT) ? r_oor : w_full_oor;
    assign w_src_inc = (w_src == ADDR_W'(DEPTH - 1)) ? '0 : w_src + 1'b1;
    assign w_ridx    = MA_W'(w_src);
    assign w_rd_word = w_src_oor ? '0 : r_mem[w_ridx];
    assign w_widx    = MA_W'(r_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_abeat_nxt = r_abeat;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_oor_nxt   = r_oor;
        w_err_nxt   = 1'b0;
        w_dv_nxt    = 1'b0;
        w_data_nxt  = '0;
        w_we        = 1'b0;
        w_final     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_shift_nxt = w_full;
                    w_len_nxt   = i_len;
                    w_abeat_nxt = AB_W'(1);
                    if (AB > 1) w_state_nxt = ADDR;
                    else        w_final     = 1'b1;
                end
            end
            ADDR: begin
                w_shift_nxt = w_full;
                w_abeat_nxt = r_abeat + 1'b1;
                if (r_abeat == AB_W'(AB - 1)) w_final = 1'b1;
            end
            RWAIT: begin
                if (r_timer == TW'(RD_LAT - 1)) begin
                    w_state_nxt = RDATA;
                    w_dv_nxt    = 1'b1;
                    w_data_nxt  = w_rd_word;
                    w_addr_nxt  = w_src_inc;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            RDATA: begin
                if (r_cnt == r_len) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                    w_dv_nxt   = 1'b1;
                    w_data_nxt = w_rd_word;
                    w_addr_nxt = w_src_inc;
                end
            end
            WDATA: begin
                if (i_dv_in) begin
                    w_we        = !r_oor;
                    w_addr_nxt  = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
                    w_timer_nxt = '0;
                    if (r_cnt == r_len) w_state_nxt = IDLE;
                    else                w_cnt_nxt   = r_cnt + 1'b1;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_final) begin
            w_addr_nxt  = w_full;
            w_oor_nxt   = w_full_oor;
            w_err_nxt   = w_full_oor;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
            if (!i_read) begin
                w_state_nxt = WDATA;
            end else if (RD_LAT == 0) begin
                w_state_nxt = RDATA;
                w_dv_nxt    = 1'b1;
                w_data_nxt  = w_rd_word;
                w_addr_nxt  = w_src_inc;
            end else begin
                w_state_nxt = RWAIT;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_abeat <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
            r_dv    <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_abeat <= w_abeat_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_oor   <= w_oor_nxt;
            r_err   <= w_err_nxt;
            r_dv    <= w_dv_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_data  <= w_data_nxt;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clock) begin
        if (w_we) r_mem[w_widx] <= i_data_in;
    end

    assign o_data_out = r_data;
    assign o_data_oe  = r_dv;
    assign o_dv_out   = r_dv;
    assign o_busy     = r_busy;
    assign o_err      = r_err;

endmodule
